// File: rtl/id_bypass_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | id_bypass_pkg                                                        |
// | Shared ID-stage definitions: stall bus layout, ID bus width, FSM.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package id_bypass_pkg;

    localparam int c_stall_w  = 6;
    localparam int c_stall_id = 1;
    localparam int c_stall_ex = 2;

    // {valid, pc}
    localparam int c_id_bus_w = 33;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_WAIT = 1'b1
    } id_state_e;

    function automatic logic [4:0] inst_rs(input logic [31:0] inst);
        return inst[25:21];
    endfunction

    function automatic logic [4:0] inst_rt(input logic [31:0] inst);
        return inst[20:16];
    endfunction

endpackage
`default_nettype wire

// File: rtl/id_bypass_fwd_mux.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fwd_mux                                                              |
// | Priority operand bypass: lowest-index matching source wins.          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module fwd_mux #(
    parameter int NUM_FWD = 3,
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5
) (
    input  logic [RADDR_W-1:0]         i_raddr,
    input  logic [DATA_W-1:0]          i_rf_rdata,
    input  logic [NUM_FWD-1:0]         i_fwd_we,
    input  logic [NUM_FWD-1:0]         i_fwd_pending,
    input  logic [NUM_FWD*RADDR_W-1:0] i_fwd_waddr,
    input  logic [NUM_FWD*DATA_W-1:0]  i_fwd_wdata,
    output logic [DATA_W-1:0]          o_data,
    output logic                       o_pending
);

    logic [NUM_FWD-1:0] w_hit;
    logic               w_zero;

    assign w_zero = (i_raddr == '0);

    generate
        for (genvar i = 0; i < NUM_FWD; i++) begin : g_hit
            assign w_hit[i] = i_fwd_we[i] && !w_zero &&
                              (i_fwd_waddr[i*RADDR_W +: RADDR_W] == i_raddr);
        end
    endgenerate

    // Walk oldest to youngest so the youngest match is the last assignment.
    always_comb begin
        o_data    = w_zero ? '0 : i_rf_rdata;
        o_pending = 1'b0;
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (w_hit[i]) begin
                o_data    = i_fwd_wdata[i*DATA_W +: DATA_W];
                o_pending = i_fwd_pending[i];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/id_bypass.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | id_bypass                                                            |
// | ID-stage register, operand bypass and load-use interlock.            |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module id_bypass
    import id_bypass_pkg::*;
#(
    parameter int NUM_FWD = 3,
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5,
    parameter int CNT_W   = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [c_stall_w-1:0]       stall,
    input  logic                       flush,
    input  logic                       if_valid,
    input  logic [31:0]                if_pc,
    input  logic [31:0]                inst,
    output logic [RADDR_W-1:0]         rf_raddr1,
    output logic [RADDR_W-1:0]         rf_raddr2,
    input  logic [DATA_W-1:0]          rf_rdata1,
    input  logic [DATA_W-1:0]          rf_rdata2,
    input  logic [NUM_FWD-1:0]         fwd_we,
    input  logic [NUM_FWD-1:0]         fwd_pending,
    input  logic [NUM_FWD*RADDR_W-1:0] fwd_waddr,
    input  logic [NUM_FWD*DATA_W-1:0]  fwd_wdata,
    output logic                       id_valid,
    output logic [31:0]                id_pc,
    output logic [31:0]                id_inst,
    output logic [DATA_W-1:0]          src1_data,
    output logic [DATA_W-1:0]          src2_data,
    output logic                       stallreq,
    output logic [CNT_W-1:0]           stall_cycles
);

    logic [c_id_bus_w-1:0] r_id_bus;
    logic [31:0]           r_inst_hold;
    id_state_e             r_state;
    id_state_e             w_state_nxt;
    logic [CNT_W-1:0]      r_stall_cycles;

    logic [31:0]           w_inst;
    logic                  w_pend1;
    logic                  w_pend2;
    logic                  w_hazard;
    logic                  w_unused_stall;

    assign w_unused_stall = ^{stall[c_stall_w-1:c_stall_ex+1], stall[0]};

    // While waiting, decode from the captured word so the operands cannot shift.
    assign w_inst    = (r_state == ST_WAIT) ? r_inst_hold : inst;
    assign rf_raddr1 = RADDR_W'(inst_rs(w_inst));
    assign rf_raddr2 = RADDR_W'(inst_rt(w_inst));

    fwd_mux #(
        .NUM_FWD (NUM_FWD),
        .DATA_W  (DATA_W),
        .RADDR_W (RADDR_W)
    ) u_fwd_mux_src1 (
        .i_raddr       (rf_raddr1),
        .i_rf_rdata    (rf_rdata1),
        .i_fwd_we      (fwd_we),
        .i_fwd_pending (fwd_pending),
        .i_fwd_waddr   (fwd_waddr),
        .i_fwd_wdata   (fwd_wdata),
        .o_data        (src1_data),
        .o_pending     (w_pend1)
    );

    fwd_mux #(
        .NUM_FWD (NUM_FWD),
        .DATA_W  (DATA_W),
        .RADDR_W (RADDR_W)
    ) u_fwd_mux_src2 (
        .i_raddr       (rf_raddr2),
        .i_rf_rdata    (rf_rdata2),
        .i_fwd_we      (fwd_we),
        .i_fwd_pending (fwd_pending),
        .i_fwd_waddr   (fwd_waddr),
        .i_fwd_wdata   (fwd_wdata),
        .o_data        (src2_data),
        .o_pending     (w_pend2)
    );

    assign w_hazard = r_id_bus[c_id_bus_w-1] && (w_pend1 || w_pend2);
    assign stallreq = w_hazard;

    assign id_valid     = r_id_bus[c_id_bus_w-1];
    assign id_pc        = r_id_bus[31:0];
    assign id_inst      = id_valid ? w_inst : 32'h0;
    assign stall_cycles = r_stall_cycles;

    // A hazard holds the ID register on its own, independent of the stall vector.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_id_bus <= '0;
        end else if (w_hazard) begin
            r_id_bus <= r_id_bus;
        end else if (!stall[c_stall_id]) begin
            r_id_bus <= {if_valid, if_pc};
        end else if (!stall[c_stall_ex]) begin
            r_id_bus <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_inst_hold <= '0;
        end else if (r_state == ST_RUN) begin
            r_inst_hold <= inst;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN:  if (w_hazard)  w_state_nxt = ST_WAIT;
            ST_WAIT: if (!w_hazard) w_state_nxt = ST_RUN;
            default: w_state_nxt = ST_RUN;
        endcase
        if (flush) begin
            w_state_nxt = ST_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles <= '0;
        end else if (w_hazard && (r_stall_cycles != '1)) begin
            r_stall_cycles <= r_stall_cycles + CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: doc/id_bypass.md
ID_BYPASS -- requirements
Module: id_bypass

Interface
REQ-001 SHALL have parameter NUM_FWD, default 3, number of forwarding sources; index 0 is the youngest stage (EX), then MEM, then WB.
REQ-002 SHALL have parameter DATA_W, default 32, register data width.
REQ-003 SHALL have parameter RADDR_W, default 5, register address width.
REQ-004 SHALL have parameter CNT_W, default 16, stall-counter width.
REQ-005 SHALL have port clk  in  1  the single clock; all state updates on the rising edge.
REQ-006 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-007 SHALL have port stall  in  `StallBus  pipeline stall vector; bit 1 holds ID input, bit 2 holds EX.
REQ-008 SHALL have port flush  in  1  discard the instruction held in ID.
REQ-009 SHALL have port if_valid, if_pc  in  1, 32  fetch-side instruction valid flag and PC.
REQ-010 SHALL have port inst  in  32  instruction word, arriving with the ID-stage PC.
REQ-011 SHALL have port rf_raddr1, rf_raddr2  out  RADDR_W each  regfile read addresses = inst[25:21] and inst[20:16].
REQ-012 SHALL have port rf_rdata1, rf_rdata2  in  DATA_W each  regfile read data.
REQ-013 SHALL have port fwd_we, fwd_pending  in  NUM_FWD each  per-source write enable; result not yet available (load in flight).
REQ-014 SHALL have port fwd_waddr, fwd_wdata  in  NUM_FWD*RADDR_W, NUM_FWD*DATA_W  per-source destination and data, source i in slice i.
REQ-015 SHALL have port id_valid, id_pc, id_inst  out  1, 32, 32  registered ID-stage instruction.
REQ-016 SHALL have port src1_data, src2_data  out  DATA_W each  bypassed operands.
REQ-017 SHALL have port stallreq  out  1  ID stall request to the stall controller.
REQ-018 SHALL have port stall_cycles  out  CNT_W  saturating count of interlock cycles.

Function
REQ-019 ID register SHALL load {if_valid, if_pc} when stall[1]=0, load zero (bubble) when stall[1]=1 and stall[2]=0, and hold otherwise.
REQ-020 flush SHALL zero the ID register on the next edge, overriding stall.
REQ-021 Operand selection SHALL be combinational: the lowest index i with fwd_we[i]=1, fwd_waddr[i] equal to the read address and that address nonzero wins; with no match, regfile data is used.
REQ-022 A read of address 0 SHALL yield 0 regardless of forwarding sources or regfile data.
REQ-023 If the winning source has fwd_pending=1 and id_valid=1, a hazard SHALL be flagged for that operand; an older non-pending match SHALL NOT mask it.
REQ-024 stallreq SHALL equal the hazard flag (combinational, same cycle); it SHALL be 0 when id_valid=0.
REQ-025 FSM SHALL have states RUN and WAIT: RUN->WAIT on hazard; WAIT->RUN when the hazard clears; flush or rst forces RUN.
REQ-026 In WAIT, id_pc and id_inst SHALL remain stable; the instruction SHALL be released the cycle the hazard clears (load-use penalty is one cycle when the load moves from source 0 to source 1).
REQ-027 stall_cycles SHALL increment once per cycle with stallreq=1 and saturate at all-ones without wrapping.
REQ-028 When a hazard and flush occur in the same cycle, flush SHALL win: the next-cycle FSM state is RUN and id_valid=0, while the stall_cycles increment for that cycle still counts.

Reset
REQ-029 On rst: id_valid=0, id_pc=0, id_inst=0, FSM=RUN, stall_cycles=0; consequently stallreq=0 the following cycle.
REQ-030 rst asserted while in WAIT SHALL abandon the held instruction with no residual stall.

Structure
REQ-031 FSM state encoding, stall-bit indices and the ID bus width SHALL live in the shared defines package (lib/defines.vh).
REQ-032 The per-operand priority match SHALL be one sub-module, fwd_mux, instantiated twice.

Verification
REQ-033 Bench SHALL drive EX writes $5=0x11, WB writes $5=0x22, ID reads rs=$5 -> src1_data=0x11.
REQ-034 Bench SHALL drive EX fwd_pending on $8 with ID reading rt=$8 -> stallreq=1 for 1 cycle, stall_cycles=1; next cycle, with the load now at MEM (not pending) holding 0xABCD -> src2_data=0xABCD and the instruction is released.
REQ-035 Bench SHALL drive all sources writing $0=0xFFFF_FFFF -> src1_data=src2_data=0.
REQ-036 Bench SHALL assert a hazard and flush together -> next cycle id_valid=0, stallreq=0, FSM=RUN.
REQ-037 Bench SHALL preload stall_cycles to all-ones minus 1 and hold the hazard for 3 cycles -> stall_cycles=0xFFFF, no wrap.
REQ-038 Bench SHALL assert rst mid-WAIT -> next cycle all outputs at reset values, stallreq=0.
